// File: rtl/parser_pkg.sv
// Shared definitions for the shunting-yard parser: token kinds, opcodes,
// the token layout, operator precedence helpers and the FSM state encoding.
package parser_pkg;

  localparam logic [3:0] KIND_NUM    = 4'd1;
  localparam logic [3:0] KIND_OP     = 4'd2;
  localparam logic [3:0] KIND_LPAREN = 4'd3;
  localparam logic [3:0] KIND_RPAREN = 4'd4;
  localparam logic [3:0] KIND_END    = 4'd5;
  localparam logic [3:0] KIND_ERR    = 4'd6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;

  // Stack entries are 3-bit operator codes; an open parenthesis uses a code
  // that no real operator occupies so it never compares as an operator.
  localparam logic [2:0] STK_LPAREN = 3'd7;

  localparam logic [15:0] TOK_END = {KIND_END, 12'h000};
  localparam logic [15:0] TOK_ERR = {KIND_ERR, 12'h000};

  typedef struct packed {
    logic [3:0]  kind;
    logic [11:0] value;
  } token_t;

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_POP,
    ST_PAREN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  function automatic logic [1:0] opPrec(input logic [2:0] op);
    logic [1:0] prec;
    case (op)
      OP_ADD, OP_SUB: prec = 2'd1;
      OP_MUL, OP_DIV: prec = 2'd2;
      OP_NEG:         prec = 2'd3;
      default:        prec = 2'd0;
    endcase
    return prec;
  endfunction

  // True when the stacked operator must leave before the pending one is
  // pushed. NEG is right-associative, so equal precedence does not pop it.
  function automatic logic shouldPop(input logic [2:0] top, input logic [2:0] pending);
    logic result;
    if (top == STK_LPAREN) begin
      result = 1'b0;
    end else if (pending == OP_NEG) begin
      result = (opPrec(top) > opPrec(pending));
    end else begin
      result = (opPrec(top) >= opPrec(pending));
    end
    return result;
  endfunction

  function automatic logic [15:0] opToken(input logic [2:0] op);
    return {KIND_OP, 9'd0, op};
  endfunction

endpackage

// File: rtl/shunting_parser_op_stack.sv
// Operator stack for the shunting-yard parser. Holds 3-bit operator codes,
// exposes the top entry combinationally and supports push, pop and clear.
// Clear has priority over push, push over pop.
module op_stack #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [2:0] i_pushData,
  input  logic       i_pop,
  input  logic       i_clear,
  output logic [2:0] o_top,
  output logic       o_empty,
  output logic       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [2:0]    r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [AW-1:0] w_wrIdx;
  logic [AW-1:0] w_topIdx;
  logic          w_doPush;
  logic          w_doPop;

  assign w_wrIdx  = r_ptr[AW-1:0];
  assign w_topIdx = r_ptr[AW-1:0] - AW'(1);
  assign o_top    = r_mem[w_topIdx];
  assign o_empty  = (r_ptr == '0);
  assign o_full   = (r_ptr == PW'(DEPTH));
  assign w_doPush = i_push && !o_full && !i_clear;
  assign w_doPop  = i_pop && !o_empty && !i_clear && !i_push;

  // Stack pointer: counts occupied entries, cleared on reset or error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (w_doPush) begin
      r_ptr <= r_ptr + PW'(1);
    end else if (w_doPop) begin
      r_ptr <= r_ptr - PW'(1);
    end
  end

  // Storage array: written only on an accepted push; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[w_wrIdx] <= i_pushData;
    end
  end

endmodule

// File: rtl/shunting_parser.sv
// Infix-to-RPN parser front stage. Consumes lexer tokens, reorders them into
// postfix with an operator stack and replaces any malformed expression with
// a single ERR token. Optional unary minus support: PARSER_UNARY_MINUS_EN.
module shunting_parser
  import parser_pkg::*;
#(
  parameter int STACK_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [15:0] O_DATA,
  output logic        BUSY
);

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_live;
  logic        r_expect;
  logic        w_expectNext;
  logic [2:0]  r_pending;
  logic [2:0]  w_pendingNext;
  logic        r_oValid;
  logic [15:0] r_oData;
  logic        w_loadOut;
  logic [15:0] w_outData;
  logic        w_push;
  logic [2:0]  w_pushData;
  logic        w_pop;
  logic        w_clear;
  logic [2:0]  w_top;
  logic        w_empty;
  logic        w_full;
  logic        w_outFree;
  logic        w_accept;
  logic        w_syntaxErr;
  logic        w_isBinOp;
  token_t      w_tok;

  assign w_tok     = I_DATA;
  assign w_outFree = !r_oValid || O_READY;
  assign I_READY   = r_live && ((r_state == ST_ACCEPT) || (r_state == ST_DRAIN)) && w_outFree;
  assign w_accept  = I_VALID && I_READY;
  assign w_isBinOp = (w_tok.value[11:3] == 9'd0) && (w_tok.value[2:0] <= OP_DIV);
  assign O_VALID   = r_oValid;
  assign O_DATA    = r_oData;
  assign BUSY      = !w_empty || (r_state != ST_ACCEPT);

  op_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .i_clear    (w_clear),
    .o_top      (w_top),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state, stack control and output-load decisions for every state.
  always_comb begin
    w_stateNext   = r_state;
    w_expectNext  = r_expect;
    w_pendingNext = r_pending;
    w_push        = 1'b0;
    w_pushData    = r_pending;
    w_pop         = 1'b0;
    w_clear       = 1'b0;
    w_loadOut     = 1'b0;
    w_outData     = r_oData;
    w_syntaxErr   = 1'b0;

    case (r_state)
      ST_ACCEPT: begin
        if (w_accept) begin
          case (w_tok.kind)
            KIND_NUM: begin
              if (r_expect) begin
                w_loadOut    = 1'b1;
                w_outData    = I_DATA;
                w_expectNext = 1'b0;
              end else begin
                w_syntaxErr = 1'b1;
              end
            end
            KIND_OP: begin
              if (r_expect) begin
`ifdef PARSER_UNARY_MINUS_EN
                if ((w_tok.value == {9'd0, OP_SUB}) && !w_full) begin
                  w_push        = 1'b1;
                  w_pushData    = OP_NEG;
                  w_pendingNext = OP_NEG;
                end else begin
                  w_syntaxErr = 1'b1;
                end
`else
                w_syntaxErr = 1'b1;
`endif
              end else if (!w_isBinOp) begin
                w_syntaxErr = 1'b1;
              end else begin
                w_pendingNext = w_tok.value[2:0];
                w_expectNext  = 1'b1;
                if (!w_empty && shouldPop(w_top, w_tok.value[2:0])) begin
                  w_stateNext = ST_POP;
                end else if (w_full) begin
                  w_syntaxErr = 1'b1;
                end else begin
                  w_push     = 1'b1;
                  w_pushData = w_tok.value[2:0];
                end
              end
            end
            KIND_LPAREN: begin
              if (!r_expect || w_full) begin
                w_syntaxErr = 1'b1;
              end else begin
                w_push     = 1'b1;
                w_pushData = STK_LPAREN;
              end
            end
            KIND_RPAREN: begin
              if (r_expect) begin
                w_syntaxErr = 1'b1;
              end else begin
                w_stateNext = ST_PAREN;
              end
            end
            KIND_END: begin
              if (r_expect) begin
                w_loadOut = 1'b1;
                w_outData = TOK_ERR;
                w_clear   = 1'b1;
              end else begin
                w_stateNext  = ST_FLUSH;
                w_expectNext = 1'b1;
              end
            end
            default: begin
              w_syntaxErr = 1'b1;
            end
          endcase
        end
      end

      ST_POP: begin
        if (!w_empty && shouldPop(w_top, r_pending)) begin
          if (w_outFree) begin
            w_loadOut = 1'b1;
            w_outData = opToken(w_top);
            w_pop     = 1'b1;
          end
        end else if (w_full) begin
          w_syntaxErr = 1'b1;
        end else begin
          w_push      = 1'b1;
          w_pushData  = r_pending;
          w_stateNext = ST_ACCEPT;
        end
      end

      ST_PAREN: begin
        if (w_empty) begin
          w_syntaxErr = 1'b1;
        end else if (w_top == STK_LPAREN) begin
          w_pop       = 1'b1;
          w_stateNext = ST_ACCEPT;
        end else if (w_outFree) begin
          w_loadOut = 1'b1;
          w_outData = opToken(w_top);
          w_pop     = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (w_outFree) begin
          w_loadOut = 1'b1;
          if (w_empty) begin
            w_outData   = TOK_END;
            w_stateNext = ST_ACCEPT;
          end else if (w_top == STK_LPAREN) begin
            w_outData    = TOK_ERR;
            w_clear      = 1'b1;
            w_stateNext  = ST_ACCEPT;
            w_expectNext = 1'b1;
          end else begin
            w_outData = opToken(w_top);
            w_pop     = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (w_accept && (w_tok.kind == KIND_END)) begin
          w_loadOut    = 1'b1;
          w_outData    = TOK_ERR;
          w_stateNext  = ST_ACCEPT;
          w_expectNext = 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_ACCEPT;
      end
    endcase

    if (w_syntaxErr) begin
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_loadOut    = 1'b0;
      w_outData    = r_oData;
      w_clear      = 1'b1;
      w_stateNext  = ST_DRAIN;
      w_expectNext = 1'b1;
    end
  end

  // Datapath registers: syntax flag, pending operator and the output slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_live    <= 1'b0;
      r_expect  <= 1'b1;
      r_pending <= OP_ADD;
      r_oValid  <= 1'b0;
      r_oData   <= '0;
    end else begin
      r_live    <= 1'b1;
      r_expect  <= w_expectNext;
      r_pending <= w_pendingNext;
      if (w_loadOut) begin
        r_oValid <= 1'b1;
        r_oData  <= w_outData;
      end else if (O_READY) begin
        r_oValid <= 1'b0;
      end
    end
  end

endmodule
